level_histogram: RTL

- Parametrised successor to the fixed 10-bin amplitude classifier. Takes signed audio samples with a valid strobe and converts them to magnitude internally.
- Each sample falls into one of NUM_BINS bins, set by runtime-programmable ascending thresholds. Samples are counted over a window of WINDOW enabled clock cycles.
- At window end it scans the bins sequentially and reports the most-populated bin index and its count.
- Sits between Audio_Controller (left_channel_audio_in, audio_in_available) and the decibel display logic.

---
 rtl/level_histogram.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/level_histogram.sv
// level_histogram: magnitude histogram of a signed sample stream.
// Samples are binned against programmable ascending thresholds over a window
// of enabled cycles. At window end the bins are scanned in order and the
// most-populated bin (lowest index on ties) is reported with its count.
module level_histogram #(
  parameter int SAMPLE_W = 32,
  parameter int NUM_BINS = 10,
  parameter int BIN_W    = 4,
  parameter int CNT_W    = 32,
  parameter int WINDOW   = 25000000
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic                                   sample_valid,
  input  logic signed [SAMPLE_W-1:0]             sample,
  input  logic [(NUM_BINS-1)*(SAMPLE_W-1)-1:0]   thresholds,
  output logic [BIN_W-1:0]                       main_bin,
  output logic [CNT_W-1:0]                       peak_count,
  output logic                                   result_valid,
  output logic                                   busy
);

  localparam int MAG_W = SAMPLE_W - 1;
  localparam int THR_W = (NUM_BINS - 1) * MAG_W;
  localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {MAG_W{1'b0}}};

  typedef enum logic [1:0] {ACCUM, DRAIN, SCAN, REPORT} state_t;

  // Absolute value; the most negative code has no positive twin and clips.
  function automatic logic [MAG_W-1:0] sat_mag(input logic signed [SAMPLE_W-1:0] s);
    logic signed [SAMPLE_W-1:0] neg;
    neg = -s;
    if (!s[SAMPLE_W-1]) return s[MAG_W-1:0];
    if (s == S_MIN)     return {MAG_W{1'b1}};
    return neg[MAG_W-1:0];
  endfunction

  // With ascending thresholds the bin index equals the number of thresholds
  // that are <= the magnitude, so a threshold value lands in the upper bin.
  function automatic logic [BIN_W-1:0] pick_bin(input logic [MAG_W-1:0] m,
                                                input logic [THR_W-1:0] thr);
    logic [BIN_W-1:0] b;
    b = '0;
    for (int k = 0; k < NUM_BINS - 1; k++) begin
      if (m >= thr[k*MAG_W +: MAG_W]) b = b + BIN_W'(1);
    end
    return b;
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t             state_q;
  logic [WIN_W-1:0]   win_q;
  logic               drain_q;
  logic [BIN_W-1:0]   idx_q;
  logic [BIN_W-1:0]   best_bin_q;
  logic [CNT_W-1:0]   best_cnt_q;
  logic [THR_W-1:0]   thr_q;
  logic [CNT_W-1:0]   bins_q [NUM_BINS];

  logic               vld_p0, vld_p1;
  logic [MAG_W-1:0]   mag_p0;
  logic [BIN_W-1:0]   bin_p1;

  logic               accept;
  logic [CNT_W-1:0]   scan_cnt;
  logic               take;
  logic [BIN_W-1:0]   best_bin_d;
  logic [CNT_W-1:0]   best_cnt_d;

  assign accept     = (state_q == ACCUM) && enable && sample_valid;
  assign busy       = (state_q != ACCUM);
  assign scan_cnt   = bins_q[idx_q];
  assign take       = (scan_cnt > best_cnt_q);
  assign best_bin_d = take ? idx_q : best_bin_q;
  assign best_cnt_d = take ? scan_cnt : best_cnt_q;

  // Pipeline valids: bubbles move every cycle, independent of enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
    end
  end

  // Datapath stages: p0 magnitude, p1 bin select against shadow thresholds.
  always_ff @(posedge clock) begin
    mag_p0 <= sat_mag(sample);
    bin_p1 <= pick_bin(mag_p0, thr_q);
  end

  // Third stage: bump the selected bin; cleared on leaving REPORT.
  always_ff @(posedge clock) begin
    if (reset || state_q == REPORT) begin
      for (int k = 0; k < NUM_BINS; k++) bins_q[k] <= '0;
    end else if (vld_p1) begin
      bins_q[bin_p1] <= sat_inc(bins_q[bin_p1]);
    end
  end

  // Window FSM: ACCUM -> DRAIN(2) -> SCAN(NUM_BINS) -> REPORT(1) -> ACCUM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ACCUM;
      win_q        <= '0;
      drain_q      <= 1'b0;
      idx_q        <= '0;
      best_bin_q   <= '0;
      best_cnt_q   <= '0;
      thr_q        <= thresholds;
      main_bin     <= '0;
      peak_count   <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (enable) begin
            if (win_q == WIN_LAST) begin
              state_q <= DRAIN;
              drain_q <= 1'b0;
            end else begin
              win_q <= win_q + WIN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_q) begin
            state_q    <= SCAN;
            idx_q      <= '0;
            best_bin_q <= '0;
            best_cnt_q <= '0;
          end else begin
            drain_q <= 1'b1;
          end
        end
        SCAN: begin
          best_bin_q <= best_bin_d;
          best_cnt_q <= best_cnt_d;
          if (idx_q == LAST_BIN) begin
            main_bin     <= best_bin_d;
            peak_count   <= best_cnt_d;
            result_valid <= 1'b1;
            state_q      <= REPORT;
          end else begin
            idx_q <= idx_q + BIN_W'(1);
          end
        end
        REPORT: begin
          win_q   <= '0;
          thr_q   <= thresholds;
          state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule
